// File: rtl/cnn_conv3x3_stream.sv
// Streaming 3x3 convolution engine.
// Raster-order pixels are accepted one per valid_in cycle. Two line buffers hold the
// previous two rows and feed a 3x3 shift window. Each fully populated window is
// multiply-accumulated against a fixed kernel, shifted, and saturated to 8 bits.
//
// cnn_conv_buffer ports:
//   clk, rst_n                           clock, synchronous active-low reset
//   in_point, valid_in                   incoming pixel and its strobe
//   frame_column_size, frame_row_size    padded frame size, latched on pixel (0,0)
//   out_matrix                           row-major window, [2][2] = newest pixel
//   win_valid                            registered: this window produces a result
//
// cnn_conv3x3_stream ports:
//   clk, rst_n                           clock, synchronous active-low reset
//   in_point, valid_in                   incoming pixel and its strobe
//   frame_column_size, frame_row_size    padded frame width and height
//   kernel_type                          kernel table select (7..31 = identity)
//   conv_res, valid_out                  saturated result and its one-cycle strobe

module cnn_conv_buffer #(
  parameter int PIXEL_WIDTH   = 8,
  parameter int BUFFER_LENGTH = 2000,
  parameter int WIN           = 9,
  parameter int SIZE_W        = $clog2(BUFFER_LENGTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PIXEL_WIDTH-1:0]     in_point,
  input  logic                       valid_in,
  input  logic [SIZE_W-1:0]          frame_column_size,
  input  logic [SIZE_W-1:0]          frame_row_size,
  output logic [PIXEL_WIDTH*WIN-1:0] out_matrix,
  output logic                       win_valid
);
  logic [PIXEL_WIDTH-1:0]     line0 [BUFFER_LENGTH];  // row - 1
  logic [PIXEL_WIDTH-1:0]     line1 [BUFFER_LENGTH];  // row - 2
  logic [SIZE_W-1:0]          cnt_row, cnt_col, cols_q, rows_q;
  logic [SIZE_W-1:0]          cols_eff, rows_eff;
  logic                       first_pix;
  logic [PIXEL_WIDTH*WIN-1:0] next_matrix;

  // Sizes are live on the first pixel of a frame and held from then on.
  always_comb begin
    first_pix = (cnt_row == '0) && (cnt_col == '0);
    cols_eff  = first_pix ? frame_column_size : cols_q;
    rows_eff  = first_pix ? frame_row_size : rows_q;
  end

  // Each window row shifts left by one column; column 2 takes the new pixels.
  always_comb begin
    next_matrix = out_matrix;
    for (int i = 0; i < 3; i++) begin
      next_matrix[PIXEL_WIDTH*(i*3+0) +: PIXEL_WIDTH] = out_matrix[PIXEL_WIDTH*(i*3+1) +: PIXEL_WIDTH];
      next_matrix[PIXEL_WIDTH*(i*3+1) +: PIXEL_WIDTH] = out_matrix[PIXEL_WIDTH*(i*3+2) +: PIXEL_WIDTH];
    end
    next_matrix[PIXEL_WIDTH*2 +: PIXEL_WIDTH] = line1[cnt_col];
    next_matrix[PIXEL_WIDTH*5 +: PIXEL_WIDTH] = line0[cnt_col];
    next_matrix[PIXEL_WIDTH*8 +: PIXEL_WIDTH] = in_point;
  end

  // Line buffer contents are don't-care after reset, so they carry no reset.
  always_ff @(posedge clk) begin
    if (rst_n && valid_in) begin
      line1[cnt_col] <= line0[cnt_col];
      line0[cnt_col] <= in_point;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_row    <= '0;
      cnt_col    <= '0;
      cols_q     <= '0;
      rows_q     <= '0;
      out_matrix <= '0;
      win_valid  <= 1'b0;
    end else begin
      win_valid <= valid_in && (cnt_row >= SIZE_W'(2)) && (cnt_col >= SIZE_W'(2));
      if (valid_in) begin
        out_matrix <= next_matrix;
        if (first_pix) begin
          cols_q <= frame_column_size;
          rows_q <= frame_row_size;
        end
        if (cnt_col == cols_eff - SIZE_W'(1)) begin
          cnt_col <= '0;
          if (cnt_row == rows_eff - SIZE_W'(1)) cnt_row <= '0;
          else                                  cnt_row <= cnt_row + SIZE_W'(1);
        end else begin
          cnt_col <= cnt_col + SIZE_W'(1);
        end
      end
    end
  end
endmodule

module cnn_conv3x3_stream #(
  parameter int    PIXEL_WIDTH        = 8,
  parameter int    KERNEL_WIDTH       = 5,
  parameter string ADDER_TYPE         = "RIPPLE",
  parameter string MULTIPLIER_TYPE    = "ARRAY",
  parameter int    KERNEL_ROW_SIZE    = 3,
  parameter int    KERNEL_COLUMN_SIZE = 3,
  parameter int    BUFFER_LENGTH      = 2000
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [PIXEL_WIDTH-1:0]           in_point,
  input  logic [$clog2(BUFFER_LENGTH)-1:0] frame_column_size,
  input  logic [$clog2(BUFFER_LENGTH)-1:0] frame_row_size,
  input  logic                             valid_in,
  input  logic [4:0]                       kernel_type,
  output logic [PIXEL_WIDTH-1:0]           conv_res,
  output logic                             valid_out
);
  localparam int SIZE_W    = $clog2(BUFFER_LENGTH);
  localparam int WIN       = KERNEL_ROW_SIZE * KERNEL_COLUMN_SIZE;
  localparam int SUM_W     = PIXEL_WIDTH + KERNEL_WIDTH + 4;
  localparam bit USE_CLA   = (ADDER_TYPE == "CLA");
  localparam bit USE_ARRAY = (MULTIPLIER_TYPE == "ARRAY");
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2**PIXEL_WIDTH) - 1);

  logic [PIXEL_WIDTH*WIN-1:0] out_matrix;
  logic                       win_valid;
  logic [4:0]                 kern_q;
  logic signed [SUM_W-1:0]    prod, acc, shifted;
  logic [PIXEL_WIDTH-1:0]     sat;

  function automatic logic signed [KERNEL_WIDTH-1:0] coef_of(input logic [4:0] kt, input int idx);
    int c [9];
    case (kt)
      5'd1:    c = '{ 1,  2,  1,  2,  4,  2,  1,  2,  1};
      5'd2:    c = '{ 0, -1,  0, -1,  5, -1,  0, -1,  0};
      5'd3:    c = '{ 0, -1,  0, -1,  4, -1,  0, -1,  0};
      5'd4:    c = '{-1,  0,  1, -2,  0,  2, -1,  0,  1};
      5'd5:    c = '{-1, -2, -1,  0,  0,  0,  1,  2,  1};
      5'd6:    c = '{-2, -1,  0, -1,  1,  1,  0,  1,  2};
      default: c = '{ 0,  0,  0,  0,  1,  0,  0,  0,  0};
    endcase
    return KERNEL_WIDTH'(c[idx]);
  endfunction

  function automatic int shift_of(input logic [4:0] kt);
    return (kt == 5'd1) ? 4 : 0;
  endfunction

  // Shift-and-add over the unsigned pixel bits; coefficient is sign-extended first.
  function automatic logic signed [SUM_W-1:0] mul_array(input logic [PIXEL_WIDTH-1:0] pix,
                                                        input logic signed [KERNEL_WIDTH-1:0] coef);
    logic signed [SUM_W-1:0] a, c_ext;
    a     = '0;
    c_ext = SUM_W'(coef);
    for (int b = 0; b < PIXEL_WIDTH; b++)
      if (pix[b]) a = a + (c_ext <<< b);
    return a;
  endfunction

  function automatic logic signed [SUM_W-1:0] mul_behav(input logic [PIXEL_WIDTH-1:0] pix,
                                                        input logic signed [KERNEL_WIDTH-1:0] coef);
    logic signed [SUM_W-1:0] p_ext, c_ext;
    p_ext = SUM_W'($signed({1'b0, pix}));
    c_ext = SUM_W'(coef);
    return p_ext * c_ext;
  endfunction

  // Fully expanded lookahead: carry into bit i is any generate below it whose
  // path up to i propagates.
  function automatic logic signed [SUM_W-1:0] add_cla(input logic signed [SUM_W-1:0] a,
                                                      input logic signed [SUM_W-1:0] b);
    logic [SUM_W-1:0] g, p, s;
    logic             carry, term;
    g = a & b;
    p = a ^ b;
    s = '0;
    for (int i = 0; i < SUM_W; i++) begin
      carry = 1'b0;
      for (int k = 0; k < i; k++) begin
        term = g[k];
        for (int m = k + 1; m < i; m++) term = term & p[m];
        carry = carry | term;
      end
      s[i] = p[i] ^ carry;
    end
    return s;
  endfunction

  cnn_conv_buffer #(
    .PIXEL_WIDTH  (PIXEL_WIDTH),
    .BUFFER_LENGTH(BUFFER_LENGTH),
    .WIN          (WIN),
    .SIZE_W       (SIZE_W)
  ) conv_buffer (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_point         (in_point),
    .valid_in         (valid_in),
    .frame_column_size(frame_column_size),
    .frame_row_size   (frame_row_size),
    .out_matrix       (out_matrix),
    .win_valid        (win_valid)
  );

  // Kernel select travels with the window so in-flight results keep their kernel.
  always_ff @(posedge clk) begin
    if (!rst_n)        kern_q <= '0;
    else if (valid_in) kern_q <= kernel_type;
  end

  always_comb begin
    acc  = '0;
    prod = '0;
    for (int i = 0; i < WIN; i++) begin
      prod = USE_ARRAY ? mul_array(out_matrix[PIXEL_WIDTH*i +: PIXEL_WIDTH], coef_of(kern_q, i))
                       : mul_behav(out_matrix[PIXEL_WIDTH*i +: PIXEL_WIDTH], coef_of(kern_q, i));
      acc  = USE_CLA ? add_cla(acc, prod) : acc + prod;
    end
    shifted = acc >>> shift_of(kern_q);
    if (shifted[SUM_W-1])       sat = '0;
    else if (shifted > SAT_MAX) sat = '1;
    else                        sat = shifted[PIXEL_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conv_res  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= win_valid;
      if (win_valid) conv_res <= sat;
    end
  end
endmodule

// File: tb/tb_cnn_conv3x3_stream.sv
// Directed bench for cnn_conv3x3_stream: frames are streamed pixel by pixel, every
// valid_out pulse is logged with its cycle, and the log is compared against
// hand-derived result values and the expected two-cycle latency.
module tb_cnn_conv3x3_stream;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_point = '0;
  logic [10:0] frame_column_size = '0;
  logic [10:0] frame_row_size = '0;
  logic        valid_in = 1'b0;
  logic [4:0]  kernel_type = '0;
  logic [7:0]  conv_res;
  logic        valid_out;

  cnn_conv3x3_stream dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_point         (in_point),
    .frame_column_size(frame_column_size),
    .frame_row_size   (frame_row_size),
    .valid_in         (valid_in),
    .kernel_type      (kernel_type),
    .conv_res         (conv_res),
    .valid_out        (valid_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int got_v[$], got_t[$], exp_v[$], exp_t[$];
  always @(negedge clk) begin
    if (valid_out) begin
      got_v.push_back(int'(conv_res));
      got_t.push_back(cyc);
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      $error("%s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int pix_of(input int mode, input int r, input int c, input int cols);
    case (mode)
      0:       return r * cols + c;
      1:       return 100;
      2:       return (c == 2) ? 255 : 0;
      3:       return (c == 0) ? 255 : 0;
      4:       return 50;
      default: return (c + 3 * r) % 256;
    endcase
  endfunction

  // Streams up to npix pixels of a rows x cols frame, gap idle cycles after each.
  // Expected valid_out cycle = sampling edge + 1 (seen at the following negedge).
  task automatic frame(input int rows, input int cols, input int kt, input int mode,
                       input int gap, input int npix);
    int n = 0;
    kernel_type       = 5'(kt);
    frame_row_size    = 11'(rows);
    frame_column_size = 11'(cols);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        if (n < npix) begin
          in_point = 8'(pix_of(mode, r, c, cols));
          valid_in = 1'b1;
          @(posedge clk); #1;
          if (r >= 2 && c >= 2) exp_t.push_back(cyc + 1);
          valid_in = 1'b0;
          n++;
          repeat (gap) begin @(posedge clk); #1; end
        end
      end
    end
  endtask

  task automatic drain_and_check(input string tag);
    repeat (4) begin @(posedge clk); #1; end
    check({tag, " count"}, got_v.size(), exp_v.size());
    for (int i = 0; i < exp_v.size() && i < got_v.size(); i++) begin
      check($sformatf("%s val[%0d]", tag, i), got_v[i], exp_v[i]);
      check($sformatf("%s cyc[%0d]", tag, i), got_t[i], exp_t[i]);
    end
    got_v.delete(); got_t.delete(); exp_v.delete(); exp_t.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset valid_out", int'(valid_out), 0);
    check("reset conv_res", int'(conv_res), 0);
    check("reset cnt_row", int'(dut.conv_buffer.cnt_row), 0);
    check("reset cnt_col", int'(dut.conv_buffer.cnt_col), 0);
    check("reset window", (dut.conv_buffer.out_matrix == '0) ? 0 : 1, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    exp_v = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
    frame(5, 5, 0, 0, 1, 25);
    drain_and_check("ident5x5");

    exp_v = '{100, 100, 100, 100};
    frame(4, 4, 1, 1, 0, 16);
    drain_and_check("gauss4x4");

    exp_v = '{255};
    frame(3, 3, 4, 2, 0, 9);
    drain_and_check("sobelx_pos");
    exp_v = '{0};
    frame(3, 3, 4, 3, 0, 9);
    drain_and_check("sobelx_neg");

    exp_v = '{50, 50, 50, 50};
    frame(3, 4, 2, 4, 0, 12);
    check("b2b cnt_row", int'(dut.conv_buffer.cnt_row), 0);
    check("b2b cnt_col", int'(dut.conv_buffer.cnt_col), 0);
    frame(3, 4, 2, 4, 0, 12);
    drain_and_check("sharpen_b2b");

    // Stop after pixel (2,3): (2,2) result is on the output, (2,3) still in flight.
    frame(3, 5, 0, 0, 0, 14);
    check("pre-reset conv_res", int'(conv_res), 6);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midreset valid_out", int'(valid_out), 0);
    check("midreset conv_res", int'(conv_res), 0);
    check("midreset cnt_row", int'(dut.conv_buffer.cnt_row), 0);
    check("midreset cnt_col", int'(dut.conv_buffer.cnt_col), 0);
    got_v.delete(); got_t.delete(); exp_v.delete(); exp_t.delete();
    exp_v = '{4};
    frame(3, 3, 0, 0, 0, 9);
    drain_and_check("restart3x3");

    for (int c = 1; c <= 1998; c++) exp_v.push_back((c + 3) % 256);
    frame(3, 2000, 0, 5, 0, 6000);
    drain_and_check("wide2000");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
